// File: rtl/squash_input_conditioner.sv
// squash_input_conditioner: synchronize and debounce the four game buttons, derive key levels, pause toggle and new-game strobe
module squash_input_conditioner #(
  parameter int TICK_BITS = 15,
  parameter int DB_TICKS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic btn_pause_n,
  input  logic btn_new_game_n,
  output logic up_key_n,
  output logic down_key_n,
  output logic pause_n,
  output logic new_game_n
);
  localparam int CW = $clog2(DB_TICKS + 1);
  logic [3:0] raw, s1_q, s1_d, s2_q, s2_d, db_q, db_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [TICK_BITS-1:0] pre_q, pre_d;
  logic [1:0] arm_q, arm_d;
  logic up_q, up_d, down_q, down_d, pause_q, pause_d, ng_q, ng_d;
  logic tick, ev_p, ev_n, both;
  assign raw = {btn_new_game_n, btn_pause_n, btn_down_n, btn_up_n};
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    pre_d = pre_q + 1'b1;
    tick = &pre_q;
    db_d = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (tick) begin
        if (s2_q[i] == db_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == CW'(DB_TICKS - 1)) begin
          db_d[i] = ~db_q[i];
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // a button held through reset must be seen released before its press counts
    arm_d = arm_q | ({2{tick}} & s2_q[3:2] & db_q[3:2]);
    ev_p = tick & arm_q[0] & db_q[2] & ~db_d[2];
    ev_n = tick & arm_q[1] & db_q[3] & ~db_d[3];
    both = ~db_q[0] & ~db_q[1];
    up_d = both ? 1'b1 : db_q[0];
    down_d = both ? 1'b1 : db_q[1];
    pause_d = ev_n ? 1'b1 : (ev_p ? ~pause_q : pause_q);
    ng_d = ~ev_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '1;
      s2_q <= '1;
      db_q <= '1;
      cnt_q <= '0;
      pre_q <= '0;
      arm_q <= '0;
      up_q <= 1'b1;
      down_q <= 1'b1;
      pause_q <= 1'b1;
      ng_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      arm_q <= arm_d;
      up_q <= up_d;
      down_q <= down_d;
      pause_q <= pause_d;
      ng_q <= ng_d;
    end
  end
  assign up_key_n = up_q;
  assign down_key_n = down_q;
  assign pause_n = pause_q;
  assign new_game_n = ng_q;
endmodule

// File: tb/tb_squash_input_conditioner.sv
// tb_squash_input_conditioner: directed vector table plus multi-cycle sequences for the button conditioner
module tb_squash_input_conditioner;
  logic clk = 1'b0, reset = 1'b1;
  logic btn_up_n = 1'b1, btn_down_n = 1'b1, btn_pause_n = 1'b1, btn_new_game_n = 1'b1;
  logic up_key_n, down_key_n, pause_n, new_game_n;
  int checks = 0, errors = 0;
  int up_falls = 0, down_lows = 0, pause_changes = 0, ng_lows = 0, ng_falls = 0;
  logic prev_up = 1'b1, prev_pause = 1'b1, prev_ng = 1'b1;
  typedef struct {
    logic [3:0] btn;
    int cyc;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[11];

  squash_input_conditioner #(.TICK_BITS(2), .DB_TICKS(3)) dut (
    .clk(clk), .reset(reset),
    .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .btn_pause_n(btn_pause_n), .btn_new_game_n(btn_new_game_n),
    .up_key_n(up_key_n), .down_key_n(down_key_n),
    .pause_n(pause_n), .new_game_n(new_game_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (prev_up && !up_key_n) up_falls++;
      if (!down_key_n) down_lows++;
      if (prev_pause !== pause_n) pause_changes++;
      if (!new_game_n) ng_lows++;
      if (prev_ng && !new_game_n) ng_falls++;
      prev_up = up_key_n;
      prev_pause = pause_n;
      prev_ng = new_game_n;
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_new_game_n, btn_pause_n, btn_down_n, btn_up_n} = b;
  endtask

  initial begin
    int lat;
    // raw buttons {ng, pause, down, up} active low; expected {up_key_n, down_key_n, pause_n}
    tbl[0]  = '{4'b1111, 20, 3'b111};
    tbl[1]  = '{4'b1110, 20, 3'b011};
    tbl[2]  = '{4'b1100, 20, 3'b111};
    tbl[3]  = '{4'b1101, 20, 3'b101};
    tbl[4]  = '{4'b1111, 20, 3'b111};
    tbl[5]  = '{4'b1011, 20, 3'b110};
    tbl[6]  = '{4'b1111, 20, 3'b110};
    tbl[7]  = '{4'b1011, 20, 3'b111};
    tbl[8]  = '{4'b1111, 20, 3'b111};
    tbl[9]  = '{4'b1010, 20, 3'b010};
    tbl[10] = '{4'b1111, 20, 3'b110};

    step(3);
    reset = 1'b0;
    check("reset_outputs", {28'd0, up_key_n, down_key_n, pause_n, new_game_n}, 32'hf);

    for (int i = 0; i < 11; i++) begin
      set_btn(tbl[i].btn);
      step(tbl[i].cyc);
      check($sformatf("vec%0d", i), {29'd0, up_key_n, down_key_n, pause_n}, {29'd0, tbl[i].exp});
    end

    ng_lows = 0;
    ng_falls = 0;
    btn_new_game_n = 1'b0;
    step(200);
    check("ng_pulse_count", ng_falls, 1);
    check("ng_pulse_width", ng_lows, 1);
    check("ng_unpauses", pause_n, 1);
    btn_new_game_n = 1'b1;
    step(20);

    down_lows = 0;
    btn_down_n = 1'b0; step(8);
    btn_down_n = 1'b1; step(8);
    btn_down_n = 1'b0; step(8);
    btn_down_n = 1'b1; step(20);
    check("bounce_rejected", down_lows, 0);

    up_falls = 0;
    btn_up_n = 1'b0;
    lat = 0;
    while (up_key_n && lat < 20) begin step(1); lat++; end
    check("up_press_latency_ok", lat <= 15, 1);
    step(40);
    check("up_falls_once", up_falls, 1);
    check("up_held_low", up_key_n, 0);
    btn_up_n = 1'b1;
    lat = 0;
    while (!up_key_n && lat < 20) begin step(1); lat++; end
    check("up_release_latency_ok", lat <= 15, 1);
    check("up_released", up_key_n, 1);
    step(10);

    btn_pause_n = 1'b0;
    step(6);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("midreset_outputs", {28'd0, up_key_n, down_key_n, pause_n, new_game_n}, 32'hf);
    pause_changes = 0;
    step(60);
    check("held_across_reset_no_toggle", pause_changes, 0);
    check("held_across_reset_pause", pause_n, 1);
    btn_pause_n = 1'b1;
    step(30);
    check("after_release_pause", pause_n, 1);
    btn_pause_n = 1'b0;
    step(30);
    check("repress_toggles", pause_n, 0);
    check("repress_one_change", pause_changes, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
